// File: rtl/dcache_refill_if.sv
// Handshake bundle between mem1, the refill FSM, the cam array and the single-word memory bus.
// master = refill FSM side, slave = surrounding logic (mem1 / cam / bus).
interface dcache_refill_if;
    logic        miss_req;
    logic [28:4] miss_paddr;
    logic [28:12] miss_lru_tag;
    logic [1:0]  miss_lru_flags;
    logic [31:0] cam_read_data;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        busy;
    logic        done;
    logic        cam_read_req;
    logic [11:2] cam_read_index;
    logic [28:12] cam_read_tag;
    logic        cam_write_req;
    logic        cam_write_lru_way;
    logic [1:0]  cam_write_offset;
    logic [31:0] cam_write_data;
    logic [3:0]  cam_write_mask;
    logic [28:12] cam_write_tag;
    logic [1:0]  cam_write_flags;
    logic        cam_lru_update;
    logic        bus_req;
    logic        bus_we;
    logic [28:2] bus_addr;
    logic [31:0] bus_wdata;

    modport master (
        input  miss_req, miss_paddr, miss_lru_tag, miss_lru_flags, cam_read_data, bus_ack,
               bus_rdata,
        output busy, done, cam_read_req, cam_read_index, cam_read_tag, cam_write_req,
               cam_write_lru_way, cam_write_offset, cam_write_data, cam_write_mask,
               cam_write_tag, cam_write_flags, cam_lru_update, bus_req, bus_we, bus_addr,
               bus_wdata
    );

    modport slave (
        output miss_req, miss_paddr, miss_lru_tag, miss_lru_flags, cam_read_data, bus_ack,
               bus_rdata,
        input  busy, done, cam_read_req, cam_read_index, cam_read_tag, cam_write_req,
               cam_write_lru_way, cam_write_offset, cam_write_data, cam_write_mask,
               cam_write_tag, cam_write_flags, cam_lru_update, bus_req, bus_we, bus_addr,
               bus_wdata
    );
endinterface

// File: rtl/dcache_refill.sv
// Data-cache miss handler: writes back a dirty LRU victim, then fetches the missed 4-word line
// one word at a time and installs it into the LRU way.
module dcache_refill #(
    parameter string NAME = "dcache"
) (
    input logic             clk_core,
    input logic             reset_n,
    dcache_refill_if.master refill_io
);

    typedef enum logic [2:0] {
        StIdle,
        StWbRead,
        StWbCap,
        StWbBus,
        StFillBus,
        StFillWrite,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [28:4]  paddr_q, paddr_d;
    logic [28:12] victim_q, victim_d;
    logic [1:0]   flags_q, flags_d;
    logic [31:0]  data_q, data_d;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            paddr_q  <= '0;
            victim_q <= '0;
            flags_q  <= 2'b00;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            victim_q <= victim_d;
            flags_q  <= flags_d;
            data_q   <= data_d;
        end
    end

    // One data register serves both directions: victim word on writeback, fetched word on fill.
    assign refill_io.bus_wdata      = data_q;
    assign refill_io.cam_write_data = data_q;
    assign refill_io.cam_read_tag   = victim_q;
    assign refill_io.cam_write_tag  = paddr_q[28:12];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        victim_d = victim_q;
        flags_d  = flags_q;
        data_d   = data_q;

        refill_io.busy              = (state_q != StIdle);
        refill_io.done              = 1'b0;
        refill_io.cam_read_req      = 1'b0;
        refill_io.cam_read_index    = '0;
        refill_io.cam_write_req     = 1'b0;
        refill_io.cam_write_lru_way = 1'b0;
        refill_io.cam_write_offset  = 2'd0;
        refill_io.cam_write_mask    = 4'h0;
        refill_io.cam_write_flags   = 2'b00;
        refill_io.cam_lru_update    = 1'b0;
        refill_io.bus_req           = 1'b0;
        refill_io.bus_we            = 1'b0;
        refill_io.bus_addr          = '0;

        unique case (state_q)
            StIdle: begin
                if (refill_io.miss_req) begin
                    paddr_d  = refill_io.miss_paddr;
                    victim_d = refill_io.miss_lru_tag;
                    flags_d  = refill_io.miss_lru_flags;
                    cnt_d    = 2'd0;
                    state_d  = (refill_io.miss_lru_flags == 2'b11) ? StWbRead : StFillBus;
                end
            end
            StWbRead: begin
                refill_io.cam_read_req   = 1'b1;
                refill_io.cam_read_index = {paddr_q[11:4], cnt_q};
                state_d                  = StWbCap;
            end
            StWbCap: begin
                data_d  = refill_io.cam_read_data;
                state_d = StWbBus;
            end
            StWbBus: begin
                refill_io.bus_req  = 1'b1;
                refill_io.bus_we   = 1'b1;
                refill_io.bus_addr = {victim_q, paddr_q[11:4], cnt_q};
                if (refill_io.bus_ack) begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd3) ? StFillBus : StWbRead;
                end
            end
            StFillBus: begin
                refill_io.bus_req  = 1'b1;
                refill_io.bus_addr = {paddr_q, cnt_q};
                if (refill_io.bus_ack) begin
                    data_d  = refill_io.bus_rdata;
                    state_d = StFillWrite;
                end
            end
            StFillWrite: begin
                refill_io.cam_write_req     = 1'b1;
                refill_io.cam_write_lru_way = 1'b1;
                refill_io.cam_write_offset  = cnt_q;
                refill_io.cam_write_mask    = 4'hF;
                // Valid only rides on the last word so a partial line never looks valid.
                refill_io.cam_write_flags   = {1'b0, cnt_q == 2'd3};
                if (cnt_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = StFillBus;
                end
            end
            StDone: begin
                refill_io.done           = 1'b1;
                refill_io.cam_lru_update = 1'b1;
                state_d                  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    bus_hold_a: assert property (@(posedge clk_core) disable iff (!reset_n)
        refill_io.bus_req && !refill_io.bus_ack |=>
            refill_io.bus_req && $stable(refill_io.bus_addr) && $stable(refill_io.bus_we) &&
            $stable(refill_io.bus_wdata))
        else $error("%s: bus request changed before ack", NAME);

    wb_dirty_a: assert property (@(posedge clk_core) disable iff (!reset_n)
        state_q inside {StWbRead, StWbCap, StWbBus} |-> flags_q == 2'b11)
        else $error("%s: writeback of a non-dirty victim", NAME);

endmodule

// File: tb/tb_dcache_refill.sv
// Directed bench for dcache_refill: bus/cam responders plus negedge monitors, checked in sequence.
module tb_dcache_refill;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_refill_if rif ();

    dcache_refill #(.NAME("dcache")) dut (
        .clk_core  (clk),
        .reset_n   (rst_n),
        .refill_io (rif)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct packed {
        logic        we;
        logic [28:2] addr;
        logic [31:0] wdata;
    } bus_t;
    typedef struct packed {
        logic [1:0]   off;
        logic [31:0]  data;
        logic [1:0]   flags;
        logic [3:0]   mask;
        logic         way;
        logic [28:12] tag;
    } cw_t;

    bus_t busq[$];
    cw_t  cwq[$];
    bus_t b_mon;
    cw_t  c_mon;

    logic [31:0] fill_data [4];
    logic [31:0] wb_data [4];
    int          fill_delay [4];
    int          wait_q = 0;

    int done_cnt = 0, done_cyc = 0, miss_cyc = 0, pulse_err = 0;
    int w1_req_cycles = 0, cw_at_w1 = -1, unstable = 0;
    logic        prev_pending = 1'b0;
    logic [28:2] prev_addr;
    logic        prev_we;
    logic [31:0] prev_wd;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: ack when the per-word wait budget has elapsed (0 = same cycle as bus_req).
    assign rif.bus_ack   = rif.bus_req &&
                           (wait_q >= (rif.bus_we ? 0 : fill_delay[rif.bus_addr[3:2]]));
    assign rif.bus_rdata = fill_data[rif.bus_addr[3:2]];

    always @(posedge clk) begin
        if (!rif.bus_req || rif.bus_ack) wait_q <= 0;
        else wait_q <= wait_q + 1;
        if (rif.cam_read_req) rif.cam_read_data <= wb_data[rif.cam_read_index[3:2]];
    end

    always @(negedge clk) begin
        if (rif.bus_req && rif.bus_ack) begin
            b_mon.we = rif.bus_we;
            b_mon.addr = rif.bus_addr;
            b_mon.wdata = rif.bus_wdata;
            busq.push_back(b_mon);
            if (!rif.bus_we && rif.bus_addr[3:2] == 2'd1) cw_at_w1 = cwq.size();
        end
        if (rif.cam_write_req) begin
            c_mon.off = rif.cam_write_offset;
            c_mon.data = rif.cam_write_data;
            c_mon.flags = rif.cam_write_flags;
            c_mon.mask = rif.cam_write_mask;
            c_mon.way = rif.cam_write_lru_way;
            c_mon.tag = rif.cam_write_tag;
            cwq.push_back(c_mon);
        end
        if (rif.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rif.done !== rif.cam_lru_update) pulse_err++;
        if (rif.bus_req && !rif.bus_we && rif.bus_addr[3:2] == 2'd1) w1_req_cycles++;
        if (prev_pending && (!rif.bus_req || rif.bus_addr != prev_addr ||
                             rif.bus_we != prev_we || rif.bus_wdata != prev_wd)) unstable++;
        prev_pending = rst_n && rif.bus_req && !rif.bus_ack;
        prev_addr = rif.bus_addr;
        prev_we = rif.bus_we;
        prev_wd = rif.bus_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{rif.busy, rif.done, rif.cam_read_req, rif.cam_read_index, rif.cam_read_tag,
                 rif.cam_write_req, rif.cam_write_lru_way, rif.cam_write_offset,
                 rif.cam_write_data, rif.cam_write_mask, rif.cam_write_tag,
                 rif.cam_write_flags, rif.cam_lru_update, rif.bus_req, rif.bus_we,
                 rif.bus_addr, rif.bus_wdata};
    endfunction

    // miss_cyc is the cycle in which miss_req is high; latency counts that cycle as 1.
    task automatic miss(input logic [28:4] pa, input logic [28:12] vt, input logic [1:0] fl);
        @(posedge clk);
        #1;
        rif.miss_paddr = pa;
        rif.miss_lru_tag = vt;
        rif.miss_lru_flags = fl;
        rif.miss_req = 1'b1;
        miss_cyc = cyc;
        @(posedge clk);
        #1;
        rif.miss_req = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget, input string tag);
        int k = 0;
        while (done_cnt == n0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 64'(done_cnt != n0), 64'd1);
    endtask

    task automatic clear();
        busq.delete();
        cwq.delete();
        for (int i = 0; i < 4; i++) fill_delay[i] = 0;
    endtask

    int n0, nwe;

    initial begin
        rif.miss_req = 1'b0;
        rif.miss_paddr = '0;
        rif.miss_lru_tag = '0;
        rif.miss_lru_flags = 2'b00;
        rif.cam_read_data = '0;
        for (int i = 0; i < 4; i++) begin
            fill_data[i] = 32'hA000_0000 + 32'(i);
            wb_data[i] = 32'hCAFE_0000 + 32'(i);
            fill_delay[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 64'(any_out()), 64'd0);
        rst_n = 1'b1;

        // 1: clean victim, zero-wait fill
        clear();
        n0 = done_cnt;
        miss(25'h0123456, 17'h00000, 2'b01);
        wait_done(n0, 40, "t1_done");
        chk("t1_latency", 64'(done_cyc - miss_cyc + 1), 64'd10);
        chk("t1_nbus", 64'(busq.size()), 64'd4);
        chk("t1_ncw", 64'(cwq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_bus%0d", i), 64'({busq[i].we, busq[i].addr}),
                64'({1'b0, 27'h048D158 + 27'(i)}));
            chk($sformatf("t1_cw%0d_ctl", i),
                64'({cwq[i].off, cwq[i].flags, cwq[i].mask, cwq[i].way, cwq[i].tag}),
                64'({2'(i), (i == 3) ? 2'b01 : 2'b00, 4'hF, 1'b1, 17'h01234}));
            chk($sformatf("t1_cw%0d_data", i), 64'(cwq[i].data), 64'(32'hA000_0000 + i));
        end

        // 2: dirty victim -> 4 writebacks then fill
        clear();
        n0 = done_cnt;
        miss(25'h0123456, 17'h1ABCD, 2'b11);
        wait_done(n0, 60, "t2_done");
        chk("t2_latency", 64'(done_cyc - miss_cyc + 1), 64'd22);
        chk("t2_nbus", 64'(busq.size()), 64'd8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_wb%0d", i), 64'({busq[i].we, busq[i].addr}),
                64'({1'b1, 27'h6AF3558 + 27'(i)}));
            chk($sformatf("t2_wbdata%0d", i), 64'(busq[i].wdata), 64'(32'hCAFE_0000 + i));
            chk($sformatf("t2_fill%0d", i), 64'({busq[i+4].we, busq[i+4].addr}),
                64'({1'b0, 27'h048D158 + 27'(i)}));
        end
        chk("t2_ncw", 64'(cwq.size()), 64'd4);

        // 3: fill word 1 acked after 5 wait cycles
        clear();
        fill_delay[1] = 5;
        w1_req_cycles = 0;
        cw_at_w1 = -1;
        unstable = 0;
        n0 = done_cnt;
        miss(25'h0123456, 17'h00000, 2'b01);
        wait_done(n0, 60, "t3_done");
        chk("t3_req_cycles", 64'(w1_req_cycles), 64'd6);
        chk("t3_unstable", 64'(unstable), 64'd0);
        chk("t3_cw_before_ack", 64'(cw_at_w1), 64'd1);
        chk("t3_latency", 64'(done_cyc - miss_cyc + 1), 64'd15);
        chk("t3_cw1_data", 64'(cwq[1].data), 64'(32'hA000_0001));

        // 4: second miss_req while busy is dropped
        clear();
        n0 = done_cnt;
        miss(25'h0123456, 17'h00000, 2'b01);
        repeat (2) @(posedge clk);
        #1;
        rif.miss_paddr = 25'h1555555;
        rif.miss_lru_tag = 17'h0F0F0;
        rif.miss_lru_flags = 2'b11;
        rif.miss_req = 1'b1;
        @(posedge clk);
        #1;
        rif.miss_req = 1'b0;
        wait_done(n0, 40, "t4_done");
        repeat (30) @(posedge clk);
        #1;
        chk("t4_one_done", 64'(done_cnt - n0), 64'd1);
        chk("t4_nbus", 64'(busq.size()), 64'd4);
        chk("t4_idle", 64'(rif.busy), 64'd0);

        // 5: async reset during fill word 2, then a fresh miss
        clear();
        fill_delay[2] = 1000;
        n0 = 0;
        miss(25'h0123456, 17'h00000, 2'b01);
        while (!(rif.bus_req && rif.bus_addr[3:2] == 2'd2) && n0 < 40) begin
            @(negedge clk);
            n0++;
        end
        chk("t5_reached_w2", 64'(rif.bus_req && rif.bus_addr[3:2] == 2'd2), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outs", 64'(any_out()), 64'd0);
        chk("t5_busy", 64'(rif.busy), 64'd0);
        fill_delay[2] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear();
        n0 = done_cnt;
        miss(25'h1FFFFFF, 17'h00000, 2'b00);
        wait_done(n0, 40, "t5b_done");
        chk("t5b_latency", 64'(done_cyc - miss_cyc + 1), 64'd10);
        chk("t5b_bus3", 64'({busq[3].we, busq[3].addr}), 64'({1'b0, 27'h7FFFFFF}));
        chk("t5b_cw3", 64'({cwq[3].off, cwq[3].flags, cwq[3].tag}),
            64'({2'd3, 2'b01, 17'h1FFFF}));

        // 6: dirty-but-invalid skips writeback; next miss accepted right after done
        clear();
        n0 = done_cnt;
        miss(25'h0ABCDEF, 17'h1ABCD, 2'b10);
        wait_done(n0, 40, "t6_done");
        n0 = done_cnt;
        miss(25'h0000010, 17'h00000, 2'b01);
        chk("t6_accepted", 64'(rif.busy), 64'd1);
        wait_done(n0, 40, "t6b_done");
        chk("t6b_latency", 64'(done_cyc - miss_cyc + 1), 64'd10);
        nwe = 0;
        foreach (busq[i]) if (busq[i].we) nwe++;
        chk("t6_no_wb", 64'(nwe), 64'd0);
        chk("t6_nbus", 64'(busq.size()), 64'd8);
        chk("t6_first_addr", 64'(busq[0].addr), 64'(27'h2AF37BC));
        chk("lru_pulse", 64'(pulse_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
